prog_mem: RTL

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prog_mem.sv
// prog_mem: single-port-write / single-port-read program memory with a
// power-up/reset clear sweep and registered 1-cycle fetch path.
// Optional feature macro: PROG_MEM_FWD_EN -- same-cycle, same-address
// load-to-fetch forwarding (default build returns the pre-write word).
module prog_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          busy_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic [DW-1:0] fetch_data_o,
  output logic          fetch_valid_o,
  output logic          fetch_err_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_nxt;
  logic          w_clr_en;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_load_en;
  logic          w_fetch_in_range;
  logic [DW-1:0] w_fetch_word;

  logic [DW-1:0] r_fetch_data;
  logic          r_fetch_valid;
  logic          r_fetch_err;

  // Word addresses at or beyond DEPTH exist in the address space when DEPTH
  // is not a power of two; they must never touch storage.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return (32'(addr) < 32'(DEPTH));
  endfunction

  assign w_load_en        = (r_state == ST_RUN) && load_we_i && addr_in_range(load_addr_i);
  assign w_fetch_in_range = addr_in_range(fetch_addr_i);

  // State and sweep-counter register; reset restarts the sweep at word 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: CLEAR zeroes one word per cycle until the last word.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_en      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt   = ST_RUN;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + AW'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt   = ST_RUN;
        w_clr_cnt_nxt = r_clr_cnt;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign busy_o = (r_state == ST_CLEAR);

  // Storage write port: sweep zeroes in CLEAR, program loads in RUN; frozen in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_clr_en) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_load_en) begin
        r_mem[load_addr_i] <= load_data_i;
      end
    end
  end

  // Fetch word selection; with forwarding a same-address load wins over storage.
  always_comb begin
    w_fetch_word = '0;
`ifdef PROG_MEM_FWD_EN
    if (w_load_en && (load_addr_i == fetch_addr_i)) begin
      w_fetch_word = load_data_i;
    end else begin
      w_fetch_word = r_mem[fetch_addr_i];
    end
`else
    w_fetch_word = r_mem[fetch_addr_i];
`endif
  end

  // Registered fetch result; idle, CLEAR and out-of-range all present a zero word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_data  <= '0;
    end else if ((r_state == ST_RUN) && fetch_req_i) begin
      r_fetch_valid <= 1'b1;
      if (w_fetch_in_range) begin
        r_fetch_err  <= 1'b0;
        r_fetch_data <= w_fetch_word;
      end else begin
        r_fetch_err  <= 1'b1;
        r_fetch_data <= '0;
      end
    end else begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_data  <= '0;
    end
  end

  assign fetch_data_o  = r_fetch_data;
  assign fetch_valid_o = r_fetch_valid;
  assign fetch_err_o   = r_fetch_err;

endmodule
